// File: rtl/spm_req_rsp_adapter.sv
// spm_req_rsp_adapter: valid/ready front-end for a 1-cycle-latency single-port SRAM,
// with a credit-protected response FIFO so read data survives consumer back-pressure.
module spm_req_rsp_adapter #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 128,
    parameter int ByteWidth = 8,
    parameter int RspDepth  = 2,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [BeWidth-1:0]   mem_be_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 busy_o
);
    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);

    if (RspDepth < 1) begin : g_bad_depth
        $error("spm_req_rsp_adapter: RspDepth must be >= 1");
    end

    logic                 r_inflight;
    logic [PtrW-1:0]      r_rd;
    logic [PtrW-1:0]      r_wr;
    logic [CntW-1:0]      r_count;
    logic [DataWidth-1:0] r_mem [RspDepth];

    logic          w_empty;
    logic [CntW:0] w_occ;
    logic          w_fire;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered state only, so a pop frees its slot one cycle later.
    always_comb begin
        w_empty     = r_count == '0;
        w_occ       = {1'b0, r_count} + {{CntW{1'b0}}, r_inflight};
        req_ready_o = ~rst_i & (req_we_i | (w_occ < (CntW + 1)'(RspDepth)));
        w_fire      = req_valid_i & req_ready_o;
        mem_req_o   = w_fire;
        mem_we_o    = req_we_i;
        mem_addr_o  = req_addr_i;
        mem_wdata_o = req_wdata_i;
        mem_be_o    = req_we_i ? req_be_i : '0;
        w_bypass    = r_inflight & w_empty;
        rsp_valid_o = ~rst_i & (r_inflight | ~w_empty);
        rsp_rdata_o = w_bypass ? mem_rdata_i : r_mem[r_rd];
        w_pop       = rsp_valid_o & rsp_ready_i & ~w_empty;
        w_push      = r_inflight & ~(w_bypass & rsp_ready_i);
        busy_o      = ~rst_i & (r_inflight | ~w_empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_fire & ~req_we_i;
            r_rd       <= w_pop ? f_inc(r_rd) : r_rd;
            r_wr       <= w_push ? f_inc(r_wr) : r_wr;
            r_count    <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) r_mem[r_wr] <= mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(w_push && r_count == CntW'(RspDepth)))
            else $error("spm_req_rsp_adapter: response FIFO overflow");
    end
endmodule

// File: doc/spm_req_rsp_adapter.md
Name: spm_req_rsp_adapter

Overview:
- Front-end stage directly upstream of the single-port SPM data memory wrapper (1-cycle read latency, 1 port).
- Converts a valid/ready request channel into raw SRAM req/we/addr/wdata/be strobes.
- Returns read data on a valid/ready response channel. A credit-protected response FIFO absorbs read data when the consumer back-pressures, so SRAM read data is never lost.

Parameters:
- NumWords, 1024, words in downstream memory
- DataWidth, 128, data width in bits
- ByteWidth, 8, bits per byte-enable lane
- RspDepth, 2, response FIFO entries; must be >= 1 (elaboration error otherwise)
- AddrWidth, (NumWords>1)?$clog2(NumWords):1, derived; do not override
- BeWidth, ceil(DataWidth/ByteWidth), derived; do not override

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AddrWidth  word address
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  byte enables
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  read response ready
- rsp_rdata_o  out  DataWidth  read data
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AddrWidth  SRAM address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enables
- mem_rdata_i  in  DataWidth  SRAM read data, valid exactly 1 cycle after a read mem_req_o
- busy_o  out  1  read in flight or FIFO non-empty

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Clears inflight flag, FIFO pointers and count.
  - While rst_i is high: req_ready_o=0, mem_req_o=0, rsp_valid_o=0, busy_o=0.
  - Reset mid-operation drops in-flight reads and stored responses; no response is emitted for them.
- Credit:
  - occ = fifo_count + inflight, using registered values only.
  - A response pop in the current cycle does NOT free a credit until the next cycle.
- Ready:
  - Writes: req_ready_o=1 whenever not in reset.
  - Reads: req_ready_o = (occ < RspDepth).
  - req_ready_o depends on req_we_i combinationally; this path is allowed.
- Fire: fire = req_valid_i & req_ready_o.
- SRAM drive, combinational pass-through, zero added latency:
  - mem_req_o = fire.
  - mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o = the corresponding req_* inputs.
  - mem_be_o is forced to 0 on reads.
- inflight register: next = fire & ~req_we_i. At most 1 read is in flight at a time.
- Write responses: none. Writes do not touch credit.
- Response path, in the cycle after a read fire (inflight=1):
  - FIFO empty: bypass. rsp_valid_o=1, rsp_rdata_o=mem_rdata_i.
    - rsp_ready_i=1: consumed, FIFO unchanged.
    - rsp_ready_i=0: mem_rdata_i pushed into FIFO.
  - FIFO non-empty: rsp_valid_o=1 from FIFO head. mem_rdata_i pushed at tail; simultaneous pop of head allowed.
  - Credit guarantees a push never overflows; assert (sim only) push & full never occurs.
- inflight=0: rsp_valid_o = (fifo_count != 0), rsp_rdata_o = FIFO head.
- Ordering: responses are strictly in read-issue order.
- FIFO: circular buffer, pointers wrap at RspDepth (non-power-of-2 allowed), count range 0..RspDepth.
- Valid/ready rules:
  - Once rsp_valid_o rises, it and rsp_rdata_o hold until accepted.
  - Bypass data is pushed into the FIFO, so it remains stable in later cycles.
- Throughput: with RspDepth >= 2 and rsp_ready_i=1, one read per cycle is sustained. With RspDepth=1, at most one read every 2 cycles.
- busy_o = inflight | (fifo_count != 0).

Test Plan:
- Reset: rst_i=1 for 3 cycles with req_valid_i=1, read → req_ready_o=0, mem_req_o=0, rsp_valid_o=0, busy_o=0 throughout.
- Write then read:
  - Write addr 5, data 0xA5..A5, be all-ones → mem_req_o=1, mem_we_o=1 same cycle, no response.
  - Read addr 5 at cycle N, model returns data at N+1 → rsp_valid_o=1, rsp_rdata_o=0xA5..A5 at N+1.
- Streaming: RspDepth=2, rsp_ready_i=1, reads to addr 0..7 back-to-back → 8 responses on consecutive cycles, in order, req_ready_o never low.
- Back-pressure: RspDepth=2, rsp_ready_i=0, issue 4 reads → only 2 accepted, req_ready_o=0 from the 3rd. Raise rsp_ready_i → data for addr 0, 1 delivered in order, then the remaining 2 accepted.
- Writes under full FIFO: FIFO full, rsp_ready_i=0, issue write addr 9 → accepted same cycle; FIFO contents and rsp_rdata_o unchanged.
- Mid-op reset: read in flight plus 1 entry stored, assert rst_i → next cycle rsp_valid_o=0, busy_o=0; no stale response after reset deasserts.
